// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared types and default latencies for the ALU sequencer
package alu_pkg;

  typedef enum logic [1:0] {
    CMD_ADD  = 2'b00,
    CMD_SUB  = 2'b01,
    CMD_MULT = 2'b10,
    CMD_DIV  = 2'b11
  } alu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_EXEC,
    ST_DONE
  } alu_seq_state_e;

  localparam int DEF_ADD_LAT  = 1;
  localparam int DEF_MULT_LAT = 2;
  localparam int DEF_DIV_LAT  = 4;

  function automatic int lat_max3(input int x, input int y, input int z);
    int m;
    m = x;
    if (y > m) m = y;
    if (z > m) m = z;
    return m;
  endfunction

endpackage

// File: rtl/alu_lat_cnt.sv
// rtl/alu_lat_cnt.sv - loadable down-counter timing a unit's fixed latency
module alu_lat_cnt #(
  parameter int MAX_LAT = 4,
  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic [CW-1:0] load_value,
  output logic [CW-1:0] value,
  output logic          zero
);

  assign zero = (value == '0);

  // Parks at zero so a late capture still sees a stable terminal count.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      value <= '0;
    end else if (load) begin
      value <= load_value;
    end else if (!zero) begin
      value <= value - 1'b1;
    end
  end

endmodule

// File: rtl/alu_seq_ctrl.sv
// rtl/alu_seq_ctrl.sv - one-at-a-time command sequencer for the add/mult/div units
module alu_seq_ctrl
  import alu_pkg::*;
#(
  parameter int IN_WL    = 15,
  parameter int OUT_WL   = 16,
  parameter int ADD_LAT  = DEF_ADD_LAT,
  parameter int MULT_LAT = DEF_MULT_LAT,
  parameter int DIV_LAT  = DEF_DIV_LAT
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd,
  input  logic [IN_WL-1:0]  a,
  input  logic [IN_WL-1:0]  b,
  output logic              res_valid,
  input  logic              res_ready,
  output logic [OUT_WL-1:0] res,
  output logic              res_err,
  output logic              busy,
  output logic [15:0]       op_count,
  output logic [IN_WL-1:0]  add_nsub_a,
  output logic [IN_WL-1:0]  add_nsub_b,
  output logic              add_or_sub,
  input  logic [OUT_WL-1:0] add_nsub_r,
  output logic [IN_WL-1:0]  mult_a,
  output logic [IN_WL-1:0]  mult_b,
  input  logic [OUT_WL-1:0] mult_r,
  output logic [IN_WL-1:0]  div_a,
  output logic [IN_WL-1:0]  div_b,
  input  logic [OUT_WL-1:0] div_r
);

  localparam int MAX_LAT = lat_max3(ADD_LAT, MULT_LAT, DIV_LAT);
  localparam int CW = (MAX_LAT > 1) ? $clog2(MAX_LAT) : 1;

  alu_seq_state_e    state;
  alu_cmd_e          cmd_q;
  alu_cmd_e          cmd_e;
  logic              accept;
  logic              div_zero;
  logic [CW-1:0]     cnt_init;
  logic [CW-1:0]     cnt_value;
  logic              cnt_zero;
  logic              unused_cnt;
  logic [OUT_WL-1:0] sat_res;
  logic [OUT_WL-1:0] unit_r;

  assign cmd_e      = alu_cmd_e'(cmd);
  assign cmd_ready  = (state == ST_IDLE);
  assign accept     = cmd_valid & cmd_ready;
  assign div_zero   = (cmd_e == CMD_DIV) && (b == '0);
  assign unused_cnt = ^cnt_value;

  // Divide-by-zero saturates toward the sign of the dividend.
  assign sat_res = a[IN_WL-1] ? {1'b1, {(OUT_WL-1){1'b0}}}
                              : {1'b0, {(OUT_WL-1){1'b1}}};

  always_comb begin
    cnt_init = '0;
    case (cmd_e)
      CMD_ADD, CMD_SUB: cnt_init = CW'(ADD_LAT - 1);
      CMD_MULT:         cnt_init = CW'(MULT_LAT - 1);
      CMD_DIV:          cnt_init = CW'(DIV_LAT - 1);
      default:          cnt_init = '0;
    endcase
  end

  always_comb begin
    unit_r = add_nsub_r;
    case (cmd_q)
      CMD_MULT: unit_r = mult_r;
      CMD_DIV:  unit_r = div_r;
      default:  unit_r = add_nsub_r;
    endcase
  end

  alu_lat_cnt #(.MAX_LAT(MAX_LAT)) u_lat_cnt (
    .clk        (clk),
    .rst        (rst),
    .load       (accept),
    .load_value (cnt_init),
    .value      (cnt_value),
    .zero       (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ST_IDLE;
      cmd_q      <= CMD_ADD;
      res_valid  <= 1'b0;
      res        <= '0;
      res_err    <= 1'b0;
      busy       <= 1'b0;
      op_count   <= '0;
      add_nsub_a <= '0;
      add_nsub_b <= '0;
      add_or_sub <= 1'b0;
      mult_a     <= '0;
      mult_b     <= '0;
      div_a      <= '0;
      div_b      <= '0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cmd_valid) begin
            cmd_q <= cmd_e;
            busy  <= 1'b1;
            if (div_zero) begin
              state     <= ST_DONE;
              res       <= sat_res;
              res_err   <= 1'b1;
              res_valid <= 1'b1;
            end else begin
              state <= ST_EXEC;
              // Operand registers double as the command latch for the window.
              case (cmd_e)
                CMD_ADD, CMD_SUB: begin
                  add_nsub_a <= a;
                  add_nsub_b <= b;
                  add_or_sub <= (cmd_e == CMD_ADD);
                end
                CMD_MULT: begin
                  mult_a <= a;
                  mult_b <= b;
                end
                default: begin
                  div_a <= a;
                  div_b <= b;
                end
              endcase
            end
          end
        end
        ST_EXEC: begin
          if (cnt_zero) begin
            res       <= unit_r;
            res_err   <= 1'b0;
            res_valid <= 1'b1;
            state     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (res_ready) begin
            state      <= ST_IDLE;
            res_valid  <= 1'b0;
            busy       <= 1'b0;
            op_count   <= op_count + 16'd1;
            add_nsub_a <= '0;
            add_nsub_b <= '0;
            add_or_sub <= 1'b0;
            mult_a     <= '0;
            mult_b     <= '0;
            div_a      <= '0;
            div_b      <= '0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// tb/tb_alu_seq_ctrl.sv - directed self-checking bench for alu_seq_ctrl
module tb_alu_seq_ctrl;

  localparam int IN_WL = 15;
  localparam int OUT_WL = 16;

  logic              clk = 1'b0;
  logic              rst;
  logic              cmd_valid, cmd_ready;
  logic [1:0]        cmd;
  logic [IN_WL-1:0]  a, b;
  logic              res_valid, res_ready;
  logic [OUT_WL-1:0] res;
  logic              res_err, busy;
  logic [15:0]       op_count;
  logic [IN_WL-1:0]  add_nsub_a, add_nsub_b, mult_a, mult_b, div_a, div_b;
  logic              add_or_sub;
  logic [OUT_WL-1:0] add_nsub_r, mult_r, div_r;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  alu_seq_ctrl #(
    .IN_WL(IN_WL), .OUT_WL(OUT_WL), .ADD_LAT(1), .MULT_LAT(2), .DIV_LAT(4)
  ) dut (
    .clk(clk), .rst(rst),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd(cmd), .a(a), .b(b),
    .res_valid(res_valid), .res_ready(res_ready), .res(res), .res_err(res_err),
    .busy(busy), .op_count(op_count),
    .add_nsub_a(add_nsub_a), .add_nsub_b(add_nsub_b), .add_or_sub(add_or_sub),
    .add_nsub_r(add_nsub_r),
    .mult_a(mult_a), .mult_b(mult_b), .mult_r(mult_r),
    .div_a(div_a), .div_b(div_b), .div_r(div_r)
  );

  // Unit stubs: result is valid LAT cycles after the operands first appear.
  logic signed [15:0] sa, sb, ma, mb, da, db;
  logic [15:0] d1, d2;
  assign sa = {add_nsub_a[14], add_nsub_a};
  assign sb = {add_nsub_b[14], add_nsub_b};
  assign ma = {mult_a[14], mult_a};
  assign mb = {mult_b[14], mult_b};
  assign da = {div_a[14], div_a};
  assign db = {div_b[14], div_b};
  assign add_nsub_r = add_or_sub ? (sa + sb) : (sa - sb);

  always_ff @(posedge clk) begin
    mult_r <= ma * mb;
    d1     <= (db == 16'sd0) ? 16'd0 : da / db;
    d2     <= d1;
    div_r  <= d2;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [1:0] c, input logic [IN_WL-1:0] ia, input logic [IN_WL-1:0] ib);
    cmd = c; a = ia; b = ib; cmd_valid = 1'b1;
    step;
    cmd_valid = 1'b0;
  endtask

  // Called in cycle T+1; counts cycles until res_valid rises.
  task automatic wait_res(input string tag, input int lat);
    int k;
    k = 1;
    while (!res_valid && k < 20) begin
      step;
      k++;
    end
    check(tag, k, lat + 1);
  endtask

  task automatic handshake;
    res_ready = 1'b1;
    step;
    res_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1; cmd_valid = 1'b0; cmd = 2'b00; a = '0; b = '0; res_ready = 1'b0;
    step; step;
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_res_valid", res_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_res", res, 0);
    check("rst_op_count", op_count, 0);
    check("rst_add_or_sub", add_or_sub, 0);
    rst = 1'b0;
    step;

    // ADD 100 + 27
    issue(2'b00, 15'd100, 15'd27);
    check("add_or_sub_add", add_or_sub, 1);
    check("add_a", add_nsub_a, 100);
    check("add_b", add_nsub_b, 27);
    check("add_busy", busy, 1);
    check("add_cmd_ready", cmd_ready, 0);
    wait_res("add_lat", 1);
    check("add_res", res, 16'd127);
    check("add_err", res_err, 0);
    check("add_a_held", add_nsub_a, 100);
    handshake;
    check("add_count", op_count, 1);
    check("add_ready_after", cmd_ready, 1);
    check("add_a_cleared", add_nsub_a, 0);

    // SUB 5 - 9
    issue(2'b01, 15'd5, 15'd9);
    check("sub_add_or_sub", add_or_sub, 0);
    check("sub_mult_ops", {mult_a, mult_b}, 0);
    check("sub_div_ops", {div_a, div_b}, 0);
    wait_res("sub_lat", 1);
    check("sub_res", res, 16'hFFFC);
    check("sub_mult_ops_end", {mult_a, mult_b}, 0);
    check("sub_div_ops_end", {div_a, div_b}, 0);
    handshake;

    // MULT -7 * 6
    issue(2'b10, 15'h7FF9, 15'd6);
    check("mult_a", mult_a, 15'h7FF9);
    check("mult_add_ops", {add_nsub_a, add_nsub_b}, 0);
    wait_res("mult_lat", 2);
    check("mult_res", res, 16'hFFD6);
    check("mult_err", res_err, 0);
    handshake;
    check("mult_ready_after", cmd_ready, 1);

    // DIV 100 / 7
    issue(2'b11, 15'd100, 15'd7);
    check("div_b", div_b, 7);
    wait_res("div_lat", 4);
    check("div_res", res, 16'd14);
    check("div_ready_low", cmd_ready, 0);
    handshake;
    check("div_count", op_count, 4);

    // DIV -3 / 0
    issue(2'b11, 15'h7FFD, 15'd0);
    wait_res("div0n_lat", 0);
    check("div0n_res", res, 16'h8000);
    check("div0n_err", res_err, 1);
    check("div0n_ops", {div_a, div_b}, 0);
    handshake;

    // DIV 3 / 0 with backpressure and a stray command
    issue(2'b11, 15'd3, 15'd0);
    wait_res("div0p_lat", 0);
    check("div0p_res", res, 16'h7FFF);
    check("div0p_err", res_err, 1);
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        cmd = 2'b00; a = 15'd1; b = 15'd1; cmd_valid = 1'b1;
      end
      step;
      check("bp_valid", res_valid, 1);
      check("bp_res", res, 16'h7FFF);
      check("bp_err", res_err, 1);
      check("bp_ready", cmd_ready, 0);
    end
    handshake;
    check("hs_no_accept_busy", busy, 0);
    check("hs_no_accept_ops", add_nsub_a, 0);
    cmd_valid = 1'b0;
    check("bp_count", op_count, 6);

    // Reset during EXEC
    issue(2'b11, 15'd100, 15'd7);
    step;
    check("exec_busy", busy, 1);
    rst = 1'b1;
    #1;
    check("mid_rst_valid", res_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_ready", cmd_ready, 1);
    check("mid_rst_div_a", div_a, 0);
    check("mid_rst_count", op_count, 0);
    step;
    rst = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step;
      check("post_rst_no_valid", res_valid, 0);
    end

    // op_count wrap
    force dut.op_count = 16'hFFFF;
    step;
    release dut.op_count;
    step;
    check("wrap_preload", op_count, 16'hFFFF);
    issue(2'b00, 15'd1, 15'd2);
    wait_res("wrap_lat", 1);
    check("wrap_res", res, 16'd3);
    handshake;
    check("wrap_count", op_count, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/alu_seq_ctrl.md
# alu_seq_ctrl

Sequencer for the ALU datapath. Accepts one command at a time over a valid/ready handshake and routes its operands to the `add_nsub`, `mult` or `div` unit. Those units are free-running pipelines with no valid signal, so this block times each unit's fixed latency, captures the result, and returns it over a second valid/ready handshake. It also short-circuits divide-by-zero and counts completed operations.

## Interface
Parameters:
- IN_WL, 15, operand word length (signed)
- OUT_WL, 16, result word length (signed)
- ADD_LAT, 1, add_nsub pipeline latency in cycles (≥1)
- MULT_LAT, 2, mult latency (≥1)
- DIV_LAT, 4, div latency (≥1)

Ports:
- Clocking and reset: one clock; reset is asynchronous and active-high.
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  block can accept a command
- cmd  in  2  00 ADD, 01 SUB, 10 MULT, 11 DIV
- a, b  in  IN_WL  signed operands
- res_valid  out  1  result available
- res_ready  in  1  result consumed
- res  out  OUT_WL  signed result
- res_err  out  1  divide-by-zero flag, qualified by res_valid
- busy  out  1  state ≠ IDLE
- op_count  out  16  completed-operation counter
- add_nsub_a, add_nsub_b  out  IN_WL  adder operands
- add_or_sub  out  1  1 = add, 0 = subtract
- add_nsub_r  in  OUT_WL  adder result
- mult_a, mult_b  out  IN_WL  multiplier operands
- mult_r  in  OUT_WL  multiplier result
- div_a, div_b  out  IN_WL  divider operands
- div_r  in  OUT_WL  divider result

## Operation
States:
- IDLE: cmd_ready=1.
  - On cmd_valid, latch cmd, a and b.
  - Normal command: go to EXEC and load the latency counter with LAT-1 for the selected unit.
  - DIV with b==0: go straight to DONE with a saturated result. res = 2^(OUT_WL-1)-1 if a≥0, else -2^(OUT_WL-1). res_err=1.
- EXEC:
  - The selected unit's operand outputs are driven from the latched operands and held stable.
  - Non-selected units' operands are driven to 0.
  - The counter decrements each cycle. On the cycle the counter is 0, capture the unit's result into res and go to DONE.
- DONE:
  - res_valid=1. res and res_err are held stable.
  - On res_ready: go to IDLE, op_count += 1.

Rules:
- op_count wraps 16'hFFFF → 0.
- In EXEC, operand registers switch to 0 only on entry to IDLE. They stay stable for the full latency window.
- Result arithmetic is owned by the units. This block does no width conversion except the saturation constants above.
- res_err=0 for every normal completion.

Reset values:
- state=IDLE, cmd_ready=1 (combinational from state), res_valid=0, busy=0.
- res=0, res_err=0, op_count=0.
- All operand outputs =0; add_or_sub=0.

Reset mid-operation: an in-flight op is dropped with no res_valid; op_count is unchanged from 0.

## Timing
- Command accepted at edge T (cmd_valid & cmd_ready).
- Normal op: unit operands valid from T+1. res_valid rises at T+1+LAT.
- Divide-by-zero: res_valid rises at T+1.
- cmd_ready is 0 from T+1 until the cycle after the result handshake.
- Minimum issue interval is LAT+2 cycles; div-by-zero needs 2.
- No command is accepted in the same cycle as the result handshake.
- res_valid is not dependent on res_ready. Under backpressure, res and res_err stay constant while res_valid=1 & !res_ready.
- All outputs are registered except cmd_ready.

## Structure
- Package `alu_pkg`:
  - `alu_cmd_e` (ADD, SUB, MULT, DIV)
  - `alu_seq_state_e` (IDLE, EXEC, DONE)
  - default latency constants
- Sub-module `alu_lat_cnt`:
  - loadable down-counter, sized by the maximum of the three latencies
  - `load`, `value`, `zero` outputs
- Select, saturation and capture logic stay in the top.

## Test plan
Bench uses behavioural unit stubs with exact parameter latencies; IN_WL=15, OUT_WL=16.
- ADD a=100 b=27, accepted at T → add_or_sub=1, adder operands 100/27 from T+1; res_valid at T+2, res=127, res_err=0; op_count=1 after handshake.
- SUB a=5 b=9 → add_or_sub=0; res=-4 at T+2; mult_a, mult_b, div_a, div_b all 0 throughout.
- MULT -7×6 → res=-42 at T+3. DIV 100/7 → res=14 at T+5. cmd_ready low from T+1 until the cycle after each handshake.
- DIV a=-3 b=0 → res_valid at T+1, res=-32768, res_err=1, div unit operands stay 0. DIV a=3 b=0 → res=32767, res_err=1.
- Backpressure: hold res_ready=0 for 5 cycles after res_valid → res, res_err and res_valid stable; a cmd_valid pulse is not accepted.
- Assert rst during EXEC → next cycle state IDLE and all outputs at reset values, no res_valid. Separately, preload op_count to 16'hFFFF (65535 ops or force) → next completion gives 0.
